// File: rtl/debug_sequencer_if.sv
// Host/core/datapath signal bundle for the AFTAB debug sequencer.
interface debug_sequencer_if;
    logic debug_request;
    logic core_busy;
    logic load_debug_command;
    logic load_debug_command_address_argument;
    logic load_debug_command_data_argument;
    logic send_debug_command;
    logic send_debug_command_address_argument;
    logic send_debug_command_data_argument;
    logic load_debug_result;
    logic debugger_busy;
    logic debug_done;
    logic debug_error;

    modport master (
        output debug_request,
        output core_busy,
        input  load_debug_command,
        input  load_debug_command_address_argument,
        input  load_debug_command_data_argument,
        input  send_debug_command,
        input  send_debug_command_address_argument,
        input  send_debug_command_data_argument,
        input  load_debug_result,
        input  debugger_busy,
        input  debug_done,
        input  debug_error
    );

    modport slave (
        input  debug_request,
        input  core_busy,
        output load_debug_command,
        output load_debug_command_address_argument,
        output load_debug_command_data_argument,
        output send_debug_command,
        output send_debug_command_address_argument,
        output send_debug_command_data_argument,
        output load_debug_result,
        output debugger_busy,
        output debug_done,
        output debug_error
    );
endinterface

// File: rtl/debug_sequencer.sv
// AFTAB debugger control FSM: latch/send command, address and data,
// handshake with the core, capture the result; watchdog on the wait states.
module debug_sequencer #(
    parameter  int TIMEOUT_CYCLES = 1024,
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1
) (
    input  logic             clk,
    input  logic             rst,
    debug_sequencer_if.slave dbg
);

    localparam logic [3:0] IDLE        = 4'd0;
    localparam logic [3:0] L_CMD       = 4'd1;
    localparam logic [3:0] L_ADDR      = 4'd2;
    localparam logic [3:0] L_DATA      = 4'd3;
    localparam logic [3:0] S_CMD       = 4'd4;
    localparam logic [3:0] S_ADDR      = 4'd5;
    localparam logic [3:0] S_DATA      = 4'd6;
    localparam logic [3:0] WAIT_ACCEPT = 4'd7;
    localparam logic [3:0] WAIT_DONE   = 4'd8;
    localparam logic [3:0] L_RES       = 4'd9;
    localparam logic [3:0] DONE        = 4'd10;
    localparam logic [3:0] ERROR       = 4'd11;

    localparam logic [CNT_W-1:0] LIMIT =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [3:0]       r_state;
    logic [3:0]       w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             w_waiting;
    logic             w_tmo;

    assign w_waiting = (r_state == WAIT_ACCEPT) || (r_state == WAIT_DONE);

    // Counter only grows while waiting, so "at or past the limit" is the abort point
    assign w_tmo = (TIMEOUT_CYCLES != 0) && (r_cnt >= LIMIT);

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:        w_next = dbg.debug_request ? L_CMD : IDLE;
            L_CMD:       w_next = L_ADDR;
            L_ADDR:      w_next = L_DATA;
            L_DATA:      w_next = S_CMD;
            S_CMD:       w_next = S_ADDR;
            S_ADDR:      w_next = S_DATA;
            S_DATA:      w_next = WAIT_ACCEPT;
            WAIT_ACCEPT: begin
                if (dbg.core_busy)  w_next = WAIT_DONE;
                else if (w_tmo)     w_next = ERROR;
            end
            WAIT_DONE: begin
                if (!dbg.core_busy) w_next = L_RES;
                else if (w_tmo)     w_next = ERROR;
            end
            L_RES:       w_next = DONE;
            DONE:        w_next = IDLE;
            ERROR:       w_next = IDLE;
            default:     w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Cleared on the way into WAIT_ACCEPT, kept across WAIT_ACCEPT->WAIT_DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_DATA) begin
            r_cnt <= '0;
        end else if (w_waiting && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign dbg.load_debug_command                  = (r_state == L_CMD);
    assign dbg.load_debug_command_address_argument = (r_state == L_ADDR);
    assign dbg.load_debug_command_data_argument    = (r_state == L_DATA);
    assign dbg.send_debug_command                  = (r_state == S_CMD);
    assign dbg.send_debug_command_address_argument = (r_state == S_ADDR);
    assign dbg.send_debug_command_data_argument    = (r_state == S_DATA);
    assign dbg.load_debug_result                   = (r_state == L_RES);
    assign dbg.debugger_busy                       = (r_state != IDLE);
    assign dbg.debug_done                          = (r_state == DONE);
    assign dbg.debug_error                         = (r_state == ERROR);

endmodule

// File: tb/tb_debug_sequencer.sv
// Scoreboard bench for debug_sequencer: two instances (TIMEOUT 1024 and 8).
module tb_debug_sequencer;

    // {busy, lcmd, laddr, ldata, scmd, saddr, sdata, lres, done, err}
    localparam logic [9:0] V_LCMD  = 10'h300;
    localparam logic [9:0] V_LADDR = 10'h280;
    localparam logic [9:0] V_LDATA = 10'h240;
    localparam logic [9:0] V_SCMD  = 10'h220;
    localparam logic [9:0] V_SADDR = 10'h210;
    localparam logic [9:0] V_SDATA = 10'h208;
    localparam logic [9:0] V_WAIT  = 10'h200;
    localparam logic [9:0] V_LRES  = 10'h204;
    localparam logic [9:0] V_DONE  = 10'h202;
    localparam logic [9:0] V_ERR   = 10'h201;

    typedef struct packed {
        int         cyc;
        logic [9:0] v;
    } exp_t;

    logic clk;
    logic rst;
    logic req_r [2];
    logic cb_r  [2];
    logic mon_en;
    int   cyc;
    int   n_tests;
    int   n_fail;
    exp_t qa[$];
    exp_t qb[$];

    debug_sequencer_if ifa ();
    debug_sequencer_if ifb ();

    assign ifa.debug_request = req_r[0];
    assign ifa.core_busy     = cb_r[0];
    assign ifb.debug_request = req_r[1];
    assign ifb.core_busy     = cb_r[1];

    debug_sequencer #(.TIMEOUT_CYCLES(1024)) dut_a (
        .clk (clk),
        .rst (rst),
        .dbg (ifa)
    );

    debug_sequencer #(.TIMEOUT_CYCLES(8)) dut_b (
        .clk (clk),
        .rst (rst),
        .dbg (ifb)
    );

    logic [9:0] va;
    logic [9:0] vb;

    assign va = {ifa.debugger_busy,
                 ifa.load_debug_command,
                 ifa.load_debug_command_address_argument,
                 ifa.load_debug_command_data_argument,
                 ifa.send_debug_command,
                 ifa.send_debug_command_address_argument,
                 ifa.send_debug_command_data_argument,
                 ifa.load_debug_result,
                 ifa.debug_done,
                 ifa.debug_error};

    assign vb = {ifb.debugger_busy,
                 ifb.load_debug_command,
                 ifb.load_debug_command_address_argument,
                 ifb.load_debug_command_data_argument,
                 ifb.send_debug_command,
                 ifb.send_debug_command_address_argument,
                 ifb.send_debug_command_data_argument,
                 ifb.load_debug_result,
                 ifb.debug_done,
                 ifb.debug_error};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input int c, input logic [9:0] v);
        exp_t e;
        e.cyc = c;
        e.v   = v;
        if (d == 0) qa.push_back(e);
        else        qb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [9:0] act,
                       input logic [9:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic mon(input int d, input logic [9:0] v);
        exp_t e;
        int   sz;
        if (v != 10'h000) begin
            n_tests++;
            sz = (d == 0) ? qa.size() : qb.size();
            if (sz == 0) begin
                n_fail++;
                $display("FAIL unexpected_out dut%0d cyc %0d: got %h want none",
                         d, cyc, v);
            end else begin
                if (d == 0) e = qa.pop_front();
                else        e = qb.pop_front();
                if (e.cyc != cyc || e.v !== v) begin
                    n_fail++;
                    $display("FAIL out dut%0d: got %h at cyc %0d want %h at cyc %0d",
                             d, v, cyc, e.v, e.cyc);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            mon(0, va);
            mon(1, vb);
        end
    end

    task automatic push_front6(input int d, input int c0);
        push(d, c0 + 1, V_LCMD);
        push(d, c0 + 2, V_LADDR);
        push(d, c0 + 3, V_LDATA);
        push(d, c0 + 4, V_SCMD);
        push(d, c0 + 5, V_SADDR);
        push(d, c0 + 6, V_SDATA);
    endtask

    // Request in the current cycle (cycle 0); core accepts after wa wait
    // cycles and finishes after wd. hold keeps request high and toggles it
    // during the waits.
    task automatic txn(input int d, input int wa, input int wd, input bit hold);
        int c0;
        c0 = cyc;
        push_front6(d, c0);
        for (int i = 0; i < wa; i++) push(d, c0 + 7 + i, V_WAIT);
        for (int j = 0; j < wd; j++) push(d, c0 + 7 + wa + j, V_WAIT);
        push(d, c0 + 7 + wa + wd, V_LRES);
        push(d, c0 + 8 + wa + wd, V_DONE);
        req_r[d] = 1'b1;
        step();
        req_r[d] = hold;
        repeat (6) step();
        for (int i = 0; i < wa; i++) begin
            cb_r[d] = (i == wa - 1);
            if (hold) req_r[d] = (i % 2 == 0);
            step();
        end
        for (int j = 0; j < wd; j++) begin
            cb_r[d] = (j < wd - 1);
            if (hold) req_r[d] = (j % 2 == 1);
            step();
        end
        cb_r[d]  = 1'b0;
        req_r[d] = hold;
        step();
        step();
    endtask

    task automatic txn_err(input int d, input int n);
        int c0;
        c0 = cyc;
        push_front6(d, c0);
        for (int i = 0; i < n; i++) push(d, c0 + 7 + i, V_WAIT);
        push(d, c0 + 7 + n, V_ERR);
        req_r[d] = 1'b1;
        cb_r[d]  = 1'b0;
        step();
        req_r[d] = 1'b0;
        repeat (6 + n) step();
        step();
        chk("err_then_idle", (d == 0) ? va : vb, 10'h000);
    endtask

    task automatic rst_txn(input int d);
        int c0;
        c0 = cyc;
        push(d, c0 + 1, V_LCMD);
        push(d, c0 + 2, V_LADDR);
        push(d, c0 + 3, V_LDATA);
        push(d, c0 + 4, V_SCMD);
        req_r[d] = 1'b1;
        step();
        req_r[d] = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("after_rst", (d == 0) ? va : vb, 10'h000);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        mon_en   = 1'b0;
        rst      = 1'b1;
        req_r[0] = 1'b0;
        req_r[1] = 1'b0;
        cb_r[0]  = 1'b0;
        cb_r[1]  = 1'b0;
        repeat (2) step();
        chk("reset_a", va, 10'h000);
        chk("reset_b", vb, 10'h000);
        rst    = 1'b0;
        mon_en = 1'b1;
        repeat (20) step();
        chk("idle_a", va, 10'h000);
        chk("idle_b", vb, 10'h000);

        txn(0, 1, 1, 1'b0);
        txn(0, 6, 8, 1'b0);
        txn_err(1, 8);
        txn(1, 8, 1, 1'b0);
        rst_txn(0);
        step();
        txn(0, 1, 1, 1'b0);
        txn(0, 1, 1, 1'b1);
        txn(0, 2, 3, 1'b1);
        txn(0, 1, 1, 1'b0);

        repeat (3) step();
        chk("final_a", va, 10'h000);
        chk_int("drain_a", qa.size(), 0);
        chk_int("drain_b", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
